skew_fifo_bank: RTL

Bank of ARRAY_SIZE independent shift FIFOs that sits between the accelerator controller and one edge (west or north) of the systolic array. It is instantiated twice, once for the west/input edge and once for the north/weight edge. Each lane is loaded in parallel from a full bus packet in a single cycle, then drained one element per cycle while the controller holds that lane's bubble line high. Because the controller raises lane i's bubble line i cycles after lane 0, the array receives the diagonal wavefront it needs.

---
 rtl/skew_fifo_bank.sv | 56 +++++
 1 files changed

// File: rtl/skew_fifo_bank.sv
// rtl/skew_fifo_bank.sv - bank of parallel-load shift FIFOs feeding one systolic array edge
// Each lane loads a whole packet in one cycle and drains one element per bubble cycle.
module skew_fifo_bank #(
  parameter int DATA_WIDTH       = 16,
  parameter int ARRAY_SIZE       = 16,
  parameter int FIFO_BUFFER_SIZE = 16,
  parameter int COUNT_WIDTH      = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ARRAY_SIZE-1:0]                  lane_rsts,
  input  logic [ARRAY_SIZE-1:0]                  lane_injects,
  input  logic [ARRAY_SIZE-1:0]                  lane_bubbles,
  input  logic [FIFO_BUFFER_SIZE*DATA_WIDTH-1:0] input_data,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]       lane_outputs,
  output logic [ARRAY_SIZE*COUNT_WIDTH-1:0]      lane_counts,
  output logic [ARRAY_SIZE-1:0]                  lane_empty,
  output logic                                   all_empty
);

  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(FIFO_BUFFER_SIZE);

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0]  mem [FIFO_BUFFER_SIZE];
    logic [COUNT_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0]  out_q;

    // Output register is zero except right after a successful pop, so the array sees zeros outside the drain window.
    always_ff @(posedge clk) begin
      if (rst || lane_rsts[i]) begin
        for (int e = 0; e < FIFO_BUFFER_SIZE; e++) mem[e] <= '0;
        count <= '0;
        out_q <= '0;
      end else if (lane_injects[i]) begin
        for (int e = 0; e < FIFO_BUFFER_SIZE; e++)
          mem[e] <= input_data[e*DATA_WIDTH +: DATA_WIDTH];
        count <= FULL_COUNT;
        out_q <= '0;
      end else if (lane_bubbles[i] && (count != '0)) begin
        out_q <= mem[0];
        for (int e = 0; e < FIFO_BUFFER_SIZE - 1; e++) mem[e] <= mem[e+1];
        mem[FIFO_BUFFER_SIZE-1] <= '0;
        count <= count - 1'b1;
      end else begin
        out_q <= '0;
      end
    end

    assign lane_outputs[i*DATA_WIDTH +: DATA_WIDTH]   = out_q;
    assign lane_counts[i*COUNT_WIDTH +: COUNT_WIDTH]  = count;
    assign lane_empty[i]                              = (count == '0);
  end

  assign all_empty = &lane_empty;

endmodule
